// File: rtl/imem_addr_stepper.sv
// Instruction-memory address stepper: two debounced push buttons step a
// registered word address up or down, wrapping at 0 and ADDR_MAX.

// Per-button synchronizer plus debounce FSM. Also flags the clock edge on
// which the debounced level goes 0->1.
module imem_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic          sync1;
    logic          sync2;
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_inc;
    logic          level_next;

    // Two-flop synchronizer for the raw, asynchronous button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Debounce state, stability counter and registered debounced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
        end
    end

    // Next-state logic: a wait state needs DEBOUNCE_CYCLES further agreeing
    // samples after the one that entered it; any disagreeing sample backs out.
    always_comb begin
        state_next = state;
        cnt_inc    = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
        cnt_next   = '0;
        case (state)
            IDLE: begin
                if (sync2) state_next = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!sync2) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            PRESSED: begin
                if (!sync2) state_next = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (sync2) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Level is registered from the next state so it tracks the FSM exactly,
        // and the step can be taken on the same edge the level rises.
        level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
        rise       = level_next && !level;
    end

endmodule

module imem_addr_stepper #(
    parameter int unsigned ADDR_WIDTH      = 6,
    parameter int unsigned ADDR_MAX        = 63,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_up,
    input  logic                  btn_down,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_changed,
    output logic                  up_level,
    output logic                  down_level
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = ADDR_WIDTH'(ADDR_MAX);

    logic                  up_rise;
    logic                  down_rise;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  changed_next;

    imem_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_up_db (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_up),
        .level (up_level),
        .rise  (up_rise)
    );

    imem_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_down_db (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_down),
        .level (down_level),
        .rise  (down_rise)
    );

    // Step selection: simultaneous up and down steps cancel out.
    always_comb begin
        addr_next = addr;
        if (up_rise && !down_rise) begin
            addr_next = (addr == ADDR_TOP) ? '0 : addr + ADDR_WIDTH'(1);
        end else if (down_rise && !up_rise) begin
            addr_next = (addr == '0) ? ADDR_TOP : addr - ADDR_WIDTH'(1);
        end
        changed_next = (addr_next != addr);
    end

    // Address register and its one-cycle change pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr         <= '0;
            addr_changed <= 1'b0;
        end else begin
            addr         <= addr_next;
            addr_changed <= changed_next;
        end
    end

endmodule

// File: tb/tb_imem_addr_stepper.sv
// Randomized and directed bench for imem_addr_stepper with a cycle-level
// behavioural model (delay line + hysteresis run counter) as the reference.
module tb_imem_addr_stepper;

    localparam int unsigned AW  = 6;
    localparam int unsigned AMX = 63;
    localparam int unsigned DB  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          btn_up = 1'b0;
    logic          btn_down = 1'b0;
    logic [AW-1:0] addr;
    logic          addr_changed;
    logic          up_level;
    logic          down_level;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    // Reference model state
    int unsigned m_addr = 0;
    bit          m_chg = 1'b0;
    bit          m_lvl [2];
    int unsigned m_run [2];
    bit          m_dl  [2][2];

    imem_addr_stepper #(
        .ADDR_WIDTH(AW),
        .ADDR_MAX(AMX),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .addr(addr),
        .addr_changed(addr_changed),
        .up_level(up_level),
        .down_level(down_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Model of one clock edge. A button's filtered level flips once DB+1
    // consecutive delayed samples disagree with it; input is seen 2 edges late.
    task automatic model_edge(input bit r, input bit u, input bit d);
        bit raw [2];
        bit rises [2];
        raw[0] = u;
        raw[1] = d;
        if (r) begin
            m_addr = 0;
            m_chg  = 1'b0;
            for (int b = 0; b < 2; b++) begin
                m_lvl[b] = 1'b0; m_run[b] = 0; m_dl[b][0] = 1'b0; m_dl[b][1] = 1'b0;
            end
            return;
        end
        for (int b = 0; b < 2; b++) begin
            rises[b] = 1'b0;
            if (m_dl[b][1] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DB + 1) begin
                    m_lvl[b] = ~m_lvl[b];
                    m_run[b] = 0;
                    rises[b] = m_lvl[b];
                end
            end else begin
                m_run[b] = 0;
            end
            m_dl[b][1] = m_dl[b][0];
            m_dl[b][0] = raw[b];
        end
        m_chg = 1'b0;
        if (rises[0] && !rises[1]) begin
            m_addr = (m_addr + 1) % (AMX + 1);
            m_chg  = 1'b1;
        end else if (rises[1] && !rises[0]) begin
            m_addr = (m_addr + AMX) % (AMX + 1);
            m_chg  = 1'b1;
        end
    endtask

    // One clock: model the edge with the inputs present at it, then compare.
    task automatic step();
        bit r, u, d;
        r = reset; u = btn_up; d = btn_down;
        @(posedge clk);
        model_edge(r, u, d);
        #1;
        check("addr", addr, m_addr);
        check("addr_changed", addr_changed, m_chg);
        check("up_level", up_level, m_lvl[0]);
        check("down_level", down_level, m_lvl[1]);
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
        steps(2);
        reset = 1'b0;
    endtask

    // Full press/release of one button (0 = up, 1 = down).
    task automatic tap(input int unsigned b);
        if (b == 0) btn_up = 1'b1; else btn_down = 1'b1;
        steps(9);
        btn_up = 1'b0; btn_down = 1'b0;
        steps(9);
    endtask

    initial begin
        int unsigned pulses;
        int unsigned rem [2];

        // Reset state
        do_reset();
        check("reset_addr", addr, 0);
        check("reset_up_level", up_level, 0);

        // Clean press: step on edge 7, single pulse, then holds
        btn_up = 1'b1;
        pulses = 0;
        for (int unsigned i = 1; i <= 20; i++) begin
            step();
            if (addr_changed) pulses++;
            if (i == 6) check("clean_pre_edge7", addr, 0);
            if (i == 7) begin
                check("clean_edge7_addr", addr, 1);
                check("clean_edge7_pulse", addr_changed, 1);
            end
        end
        check("clean_hold_addr", addr, 1);
        check("clean_pulses", pulses, 1);
        btn_up = 1'b0;
        steps(10);

        // Bounce then stable high
        do_reset();
        btn_up = 1'b1; step(); btn_up = 1'b0; step();
        btn_up = 1'b1; step(); btn_up = 1'b0; step();
        btn_up = 1'b1;
        steps(6);
        check("bounce_before", addr, 0);
        step();
        check("bounce_edge7", addr, 1);
        btn_up = 1'b0;
        steps(10);

        // Wrap down from 0, then up from 63
        do_reset();
        tap(1);
        check("wrap_down", addr, 63);
        tap(0);
        check("wrap_up", addr, 0);

        // Simultaneous press at addr=10
        for (int unsigned k = 0; k < 10; k++) tap(0);
        check("pre_simul_addr", addr, 10);
        btn_up = 1'b1; btn_down = 1'b1;
        pulses = 0;
        for (int unsigned i = 0; i < 12; i++) begin
            step();
            if (addr_changed) pulses++;
        end
        check("simul_addr", addr, 10);
        check("simul_pulses", pulses, 0);
        check("simul_up_level", up_level, 1);
        check("simul_down_level", down_level, 1);
        btn_up = 1'b0; btn_down = 1'b0;
        steps(10);

        // Reset mid-press at addr=5, button kept held
        do_reset();
        for (int unsigned k = 0; k < 5; k++) tap(0);
        check("pre_rst_addr", addr, 5);
        btn_down = 1'b1;
        steps(3);
        reset = 1'b1;
        step();
        check("midrst_addr", addr, 0);
        check("midrst_pulse", addr_changed, 0);
        reset = 1'b0;
        steps(6);
        check("midrst_pre7", addr, 0);
        step();
        check("midrst_edge7", addr, 63);
        btn_down = 1'b0;
        steps(10);

        // Release and re-press
        do_reset();
        pulses = 0;
        btn_up = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin step(); if (addr_changed) pulses++; end
        btn_up = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin step(); if (addr_changed) pulses++; end
        btn_up = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin step(); if (addr_changed) pulses++; end
        check("repress_addr", addr, 2);
        check("repress_pulses", pulses, 2);
        btn_up = 1'b0;
        steps(10);

        // Randomized bouncing on both buttons with occasional resets
        rem[0] = 0; rem[1] = 0;
        for (int unsigned c = 0; c < 4000; c++) begin
            if (rem[0] == 0) begin btn_up = 1'($urandom_range(0, 1)); rem[0] = $urandom_range(1, 12); end
            if (rem[1] == 0) begin btn_down = 1'($urandom_range(0, 1)); rem[1] = $urandom_range(1, 12); end
            rem[0]--; rem[1]--;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
